// File: rtl/mdv_pkg.sv
// mdv_pkg: shared types and constants for the iterative multiply/divide unit.
package mdv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam int DEF_WIDTH = 32;
    // Start cycle to result-ready cycle, full iterative path.
    localparam int LAT_FULL  = DEF_WIDTH + 2;
    // Start cycle to result-ready cycle, early-zero shortcut.
    localparam int LAT_EARLY = 1;

endpackage

// File: rtl/mdv_seq_ctrl_if.sv
// mdv_seq_ctrl_if: start/operand/result bundle between the pipeline and the
// multiply/divide unit. The master side is the pipeline, the slave side is the unit.
interface mdv_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/mdv_iter_cnt.sv
// mdv_iter_cnt: iteration counter with clear/enable and a terminal count at WIDTH-1.
module mdv_iter_cnt #(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt_r;

    // Count one step per enabled cycle; clear has priority so a restart always begins at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mdv_seq_ctrl.sv
// mdv_seq_ctrl: iterative signed multiply/divide unit with its sequencing FSM.
// Magnitudes are processed in a 2*WIDTH working register (shift-add multiply,
// restoring divide); signs and exceptions are applied in a single FIX cycle.
// Optional build macro MDV_EARLY_ZERO_EN: zero-result operations skip RUN/FIX
// and report in the cycle after the start.
module mdv_seq_ctrl
    import mdv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    mdv_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_FIX  = 2'(FIX);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]         state_r, state_n;
    op_e                op_r;
    logic               neg_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] work_r;
    logic [WIDTH-1:0]   result_r;
    logic               exc_r;
    logic               rdy_r;
    logic               busy_r;

    logic               start_s;
    op_e                start_op_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               early_zero_s;
    logic               tc_s;
    logic [WIDTH:0]     mult_sum_s;
    logic [2*WIDTH-1:0] mult_next_s;
    logic [2*WIDTH-1:0] div_shift_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_res_s;
    logic               fix_exc_s;

    assign start_s    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_op_s = bus.ctrl_MULT ? OP_MULT : OP_DIV;
    // Unsigned magnitudes: INT_MIN maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
    assign mag_a_s = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + {{(WIDTH-1){1'b0}}, 1'b1})
                                                : bus.data_operandA;
    assign mag_b_s = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + {{(WIDTH-1){1'b0}}, 1'b1})
                                                : bus.data_operandB;

`ifdef MDV_EARLY_ZERO_EN
    assign early_zero_s = start_s & (bus.ctrl_MULT
        ? ((bus.data_operandA == {WIDTH{1'b0}}) | (bus.data_operandB == {WIDTH{1'b0}}))
        : ((bus.data_operandA == {WIDTH{1'b0}}) & (bus.data_operandB != {WIDTH{1'b0}})));
`else
    assign early_zero_s = 1'b0;
`endif

    mdv_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (start_s),
        .en      ((state_r == S_RUN) & ~start_s),
        .tc      (tc_s)
    );

    // One iteration step for each operation; the multiply adder keeps a carry bit.
    always_comb begin
        mult_sum_s  = {1'b0, work_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_r};
        mult_next_s = {1'b0, work_r[2*WIDTH-1:1]};
        div_shift_s = {work_r[2*WIDTH-2:0], 1'b0};
        div_next_s  = div_shift_s;
        if (work_r[0]) begin
            mult_next_s = {mult_sum_s, work_r[WIDTH-1:1]};
        end else begin
            mult_next_s = {1'b0, work_r[2*WIDTH-1:1]};
        end
        // Partial remainder stays below |B| <= 2^(WIDTH-1), so no bit is lost in the shift.
        if (div_shift_s[2*WIDTH-1:WIDTH] >= mag_b_r) begin
            div_next_s = {div_shift_s[2*WIDTH-1:WIDTH] - mag_b_r, div_shift_s[WIDTH-1:1], 1'b1};
        end else begin
            div_next_s = div_shift_s;
        end
    end

    // Sign and exception fix-up of the finished magnitude result.
    always_comb begin
        fix_res_s = {WIDTH{1'b0}};
        fix_exc_s = 1'b0;
        prod_s    = neg_r ? (~work_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : work_r;
        if (op_r == OP_MULT) begin
            fix_res_s = prod_s[WIDTH-1:0];
            // Overflow unless the upper WIDTH+1 bits are all equal (a valid sign extension).
            fix_exc_s = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
        end else if (mag_b_r == {WIDTH{1'b0}}) begin
            fix_res_s = {WIDTH{1'b0}};
            fix_exc_s = 1'b1;
        end else begin
            fix_res_s = neg_r ? (~work_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : work_r[WIDTH-1:0];
            // A positive quotient of magnitude 2^(WIDTH-1) only arises from INT_MIN / -1.
            fix_exc_s = ~neg_r & work_r[WIDTH-1];
        end
    end

    // Next-state selection; a start overrides whatever is in flight.
    always_comb begin
        state_n = state_r;
        if (start_s) begin
            state_n = early_zero_s ? S_DONE : S_RUN;
        end else begin
            case (state_r)
                S_IDLE:  state_n = S_IDLE;
                S_RUN:   state_n = tc_s ? S_FIX : S_RUN;
                S_FIX:   state_n = S_DONE;
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State plus registered handshake outputs derived from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            rdy_r   <= (state_n == S_DONE);
            busy_r  <= (state_n == S_RUN) | (state_n == S_FIX);
        end
    end

    // Operand capture at start and one working-register step per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r    <= OP_MULT;
            neg_r   <= 1'b0;
            mag_b_r <= {WIDTH{1'b0}};
            work_r  <= {(2*WIDTH){1'b0}};
        end else if (start_s) begin
            op_r    <= start_op_s;
            neg_r   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            mag_b_r <= mag_b_s;
            work_r  <= {{WIDTH{1'b0}}, mag_a_s};
        end else if (state_r == S_RUN) begin
            work_r  <= (op_r == OP_MULT) ? mult_next_s : div_next_s;
        end else begin
            work_r  <= work_r;
        end
    end

    // Result/exception update on leaving FIX (or an early-zero start); held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_r <= {WIDTH{1'b0}};
            exc_r    <= 1'b0;
        end else if (start_s && early_zero_s) begin
            result_r <= {WIDTH{1'b0}};
            exc_r    <= 1'b0;
        end else if (!start_s && (state_r == S_FIX)) begin
            result_r <= fix_res_s;
            exc_r    <= fix_exc_s;
        end else begin
            result_r <= result_r;
            exc_r    <= exc_r;
        end
    end

    assign bus.data_result    = result_r;
    assign bus.data_exception = exc_r;
    assign bus.data_resultRDY = rdy_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_mdv_seq_ctrl.sv
// tb_mdv_seq_ctrl: scoreboard bench for mdv_seq_ctrl. Expected results come from
// plain signed 64-bit arithmetic; a negedge monitor checks RDY timing, result,
// exception and the busy window.
module tb_mdv_seq_ctrl;
    import mdv_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        bit          exc;
        int          due;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_from = 1;
    int   busy_to   = 0;
    exp_t q[$];

    mdv_seq_ctrl_if #(.WIDTH(W)) bus ();

    mdv_seq_ctrl #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e);
        longint p;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            6:       return -32'($urandom_range(0, 255));
            default: return 32'($urandom());
        endcase
    endfunction

    // Drive a one-cycle start at the current cycle and record the expected response.
    task automatic issue(input bit mul, input bit both, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit e;
        bit ez;
        bit is_mult;
        is_mult = mul | both;
        bus.ctrl_MULT     = is_mult;
        bus.ctrl_DIV      = ~mul | both;
        bus.data_operandA = a;
        bus.data_operandB = b;
        model(is_mult, a, b, r, e);
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        ez = 1'b0;
`ifdef MDV_EARLY_ZERO_EN
        ez = is_mult ? (a == 32'h0 || b == 32'h0) : (a == 32'h0 && b != 32'h0);
`endif
        if (ez) begin
            q.push_back('{r, e, cyc + LAT_EARLY});
            if (busy_to >= cyc) busy_to = cyc;
            else begin busy_from = 1; busy_to = 0; end
        end else begin
            q.push_back('{r, e, cyc + LAT_FULL});
            if (busy_to < cyc) busy_from = cyc + 1;
            busy_to = cyc + LAT_FULL - 1;
        end
        @(posedge clock); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'($urandom());
        bus.data_operandB = 32'($urandom());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            @(posedge clock);
        end
        #1;
        check("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor: busy window every cycle; on RDY pop and compare; flag late results.
    always @(negedge clock) begin
        exp_t x;
        if (reset_n) begin
            check("busy", 64'(bus.busy), 64'((cyc >= busy_from) && (cyc <= busy_to)));
            if (bus.data_resultRDY) begin
                if (q.size() == 0) begin
                    check("unexpected_rdy", 64'd1, 64'd0);
                end else begin
                    x = q.pop_front();
                    check("rdy_cycle", 64'(cyc), 64'(x.due));
                    check("result", 64'(bus.data_result), 64'(x.res));
                    check("exception", 64'(bus.data_exception), 64'(x.exc));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                x = q.pop_front();
                check("missing_rdy", 64'(cyc), 64'(x.due));
            end
        end
    end

    initial begin
        int g;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;
        #1;
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exc",    64'(bus.data_exception), 64'd0);
        check("rst_rdy",    64'(bus.data_resultRDY), 64'd0);
        check("rst_busy",   64'(bus.busy), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed cases.
        issue(1'b1, 1'b0, 32'd7, -32'd6);                  wait_idle();
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);   wait_idle();
        issue(1'b0, 1'b0, -32'd7, 32'd2);                  wait_idle();
        issue(1'b0, 1'b0, 32'd5, 32'd0);                   wait_idle();
        issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
        issue(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);   wait_idle();
        issue(1'b1, 1'b0, 32'd0, 32'd9);                   wait_idle();

        // Restart: DIV issued 10 cycles into a MULT replaces it.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #1;
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        wait_idle();

        // Asynchronous reset 15 cycles into a MULT.
        issue(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (14) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_result", 64'(bus.data_result), 64'd0);
        check("mid_rst_exc",    64'(bus.data_exception), 64'd0);
        check("mid_rst_rdy",    64'(bus.data_resultRDY), 64'd0);
        check("mid_rst_busy",   64'(bus.busy), 64'd0);
        q.delete();
        busy_from = 1;
        busy_to   = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;

        // Randomized operations, some restarted at a random point (including DONE).
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, LAT_FULL);
                repeat (g - 1) @(posedge clock);
                #1;
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clock);
                #1;
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
